// File: rtl/riscv_mem_arb.sv
// riscv_mem_arb: two-port (data/fetch) arbiter onto a single shared memory bus with timeout
module riscv_mem_arb #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dmem_req,
    input  logic            dmem_we,
    input  logic [XLEN-1:0] dmem_adr,
    input  logic [XLEN-1:0] dmem_d,
    input  logic [2:0]      dmem_size,
    output logic            dmem_ack,
    output logic            dmem_err,
    output logic [XLEN-1:0] dmem_q,
    input  logic            imem_req,
    input  logic [XLEN-1:0] imem_adr,
    output logic            imem_ack,
    output logic            imem_err,
    output logic [XLEN-1:0] imem_q,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_adr,
    output logic [XLEN-1:0] bus_d,
    output logic [2:0]      bus_size,
    input  logic            bus_ack,
    input  logic            bus_err,
    input  logic [XLEN-1:0] bus_q,
    output logic            busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;
    state_t          r_state, w_next;
    logic            r_last_d;
    logic [CW-1:0]   r_cnt;
    logic            r_we;
    logic [XLEN-1:0] r_adr, r_d;
    logic [2:0]      r_size;
    logic            w_act, w_tout, w_done, w_gnt;
    // next-state selection and port/bus outputs; everything is forced quiet while rst is high
    always_comb begin
        w_act    = (r_state != IDLE) && !rst;
        w_tout   = w_act && !bus_ack && !bus_err && (r_cnt == CW'(TIMEOUT - 1));
        w_done   = w_act && (bus_ack || bus_err || w_tout);
        w_next   = r_state;
        if (r_state == IDLE)
            w_next = (dmem_req && imem_req) ? (r_last_d ? GNT_I : GNT_D) :
                     dmem_req ? GNT_D : imem_req ? GNT_I : IDLE;
        else if (w_done)
            w_next = IDLE;
        w_gnt    = (r_state == IDLE) && (w_next != IDLE);
        dmem_ack = w_act && (r_state == GNT_D) && bus_ack;
        dmem_err = w_act && (r_state == GNT_D) && !bus_ack && (bus_err || w_tout);
        dmem_q   = dmem_ack ? bus_q : '0;
        imem_ack = w_act && (r_state == GNT_I) && bus_ack;
        imem_err = w_act && (r_state == GNT_I) && !bus_ack && (bus_err || w_tout);
        imem_q   = imem_ack ? bus_q : '0;
        bus_req  = w_act;
        busy     = w_act;
        bus_we   = w_act && r_we;
        bus_adr  = w_act ? r_adr : '0;
        bus_d    = w_act ? r_d : '0;
        bus_size = w_act ? r_size : 3'b000;
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    // capture winner's request on grant, track fairness and wait cycles, clear on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b0;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_d      <= '0;
            r_size   <= 3'b000;
        end else if (w_gnt) begin
            r_cnt    <= '0;
            r_we     <= (w_next == GNT_D) && dmem_we;
            r_adr    <= (w_next == GNT_D) ? dmem_adr : imem_adr;
            r_d      <= (w_next == GNT_D) ? dmem_d : '0;
            r_size   <= (w_next == GNT_D) ? dmem_size : 3'b010;
        end else if (w_done) begin
            r_last_d <= (r_state == GNT_D);
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_d      <= '0;
            r_size   <= 3'b000;
        end else if (r_state != IDLE) begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_riscv_mem_arb.sv
// tb_riscv_mem_arb: randomized bench checking the arbiter against a transaction-level reference model
module tb_riscv_mem_arb;
    localparam int XLEN = 32;
    localparam int TMO  = 8;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            dmem_req = 1'b0, dmem_we = 1'b0;
    logic [XLEN-1:0] dmem_adr = '0, dmem_d = '0;
    logic [2:0]      dmem_size = 3'b000;
    logic            dmem_ack, dmem_err;
    logic [XLEN-1:0] dmem_q;
    logic            imem_req = 1'b0;
    logic [XLEN-1:0] imem_adr = '0;
    logic            imem_ack, imem_err;
    logic [XLEN-1:0] imem_q;
    logic            bus_req, bus_we;
    logic [XLEN-1:0] bus_adr, bus_d;
    logic [2:0]      bus_size;
    logic            bus_ack = 1'b0, bus_err = 1'b0;
    logic [XLEN-1:0] bus_q = '0;
    logic            busy;
    riscv_mem_arb #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_adr(dmem_adr), .dmem_d(dmem_d),
        .dmem_size(dmem_size), .dmem_ack(dmem_ack), .dmem_err(dmem_err), .dmem_q(dmem_q),
        .imem_req(imem_req), .imem_adr(imem_adr), .imem_ack(imem_ack), .imem_err(imem_err),
        .imem_q(imem_q), .bus_req(bus_req), .bus_we(bus_we), .bus_adr(bus_adr), .bus_d(bus_d),
        .bus_size(bus_size), .bus_ack(bus_ack), .bus_err(bus_err), .bus_q(bus_q), .busy(busy)
    );
    always #5 clk = ~clk;
    int n_err = 0;
    int n_chk = 0;
    // reference model: one outstanding transaction, its owner and how many granted cycles it has lived
    bit              m_busy = 1'b0, m_own_d = 1'b0, m_last_d = 1'b0, m_we = 1'b0;
    int              m_age = 0;
    logic [XLEN-1:0] m_adr = '0, m_d = '0;
    logic [2:0]      m_size = 3'b000;
    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask
    task automatic step(input bit r, input bit dq, input bit iq, input bit ba, input bit be);
        bit act, tout, d_ack, i_ack;
        @(negedge clk);
        rst       = r;
        dmem_req  = dq;
        imem_req  = iq;
        bus_ack   = ba;
        bus_err   = be;
        dmem_we   = 1'($urandom_range(0, 1));
        dmem_adr  = $urandom;
        dmem_d    = $urandom;
        dmem_size = 3'($urandom_range(0, 7));
        imem_adr  = $urandom;
        bus_q     = $urandom;
        #1;
        act   = m_busy && !r;
        tout  = act && (m_age == TMO) && !ba && !be;
        d_ack = act && m_own_d && ba;
        i_ack = act && !m_own_d && ba;
        check("bus_req", 32'(bus_req), 32'(act));
        check("busy", 32'(busy), 32'(act));
        check("bus_we", 32'(bus_we), 32'(act && m_we));
        check("bus_adr", bus_adr, act ? m_adr : 32'h0);
        check("bus_d", bus_d, act ? m_d : 32'h0);
        check("bus_size", 32'(bus_size), act ? 32'(m_size) : 32'h0);
        check("dmem_ack", 32'(dmem_ack), 32'(d_ack));
        check("dmem_err", 32'(dmem_err), 32'(act && m_own_d && !ba && (be || tout)));
        check("dmem_q", dmem_q, d_ack ? bus_q : 32'h0);
        check("imem_ack", 32'(imem_ack), 32'(i_ack));
        check("imem_err", 32'(imem_err), 32'(act && !m_own_d && !ba && (be || tout)));
        check("imem_q", imem_q, i_ack ? bus_q : 32'h0);
        if (r) begin
            m_busy   = 1'b0;
            m_last_d = 1'b0;
        end else if (m_busy) begin
            if (ba || be || m_age == TMO) begin
                m_busy   = 1'b0;
                m_last_d = m_own_d;
            end else begin
                m_age++;
            end
        end else if (dq || iq) begin
            m_busy  = 1'b1;
            m_own_d = dq && (!iq || !m_last_d);
            m_age   = 1;
            m_we    = m_own_d && dmem_we;
            m_adr   = m_own_d ? dmem_adr : imem_adr;
            m_d     = m_own_d ? dmem_d : 32'h0;
            m_size  = m_own_d ? dmem_size : 3'b010;
        end
    endtask
    initial begin
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (14) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (1500)
            step($urandom_range(0, 60) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0);
        repeat (800)
            step($urandom_range(0, 100) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
